igbt_fb_monitor: RTL and testbench
==================================

// Module: igbt_fb_monitor
// PURPOSE
//  Return path of the H-bridge gate-drive interface. Watches the four commanded gate
//  signals (RUDIN/RDDIN/LUDIN/LDDIN) against the driver's gate-state feedback and
//  desaturation fault lines, and latches a unit fault that drives err_unit of the PWM stage.
//  Detects shoot-through commands, feedback mismatch timeouts and filtered desat faults.
// PARAMETERS
//  FB_TIMEOUT   80   clk cycles fb may differ from cmd before trip (2us @40MHz)
//  DESAT_FILT   8    consecutive cycles drv_flt_n low before trip
//  RECOVER_CYC  400  fault-free cycles required after fault_clr before release (10us)
//  CNT_W        9    width of all internal counters; every count parameter < 2**CNT_W
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  cmd_ru       in   1  commanded right-upper gate (RUDIN), synchronous to clk
//  cmd_rd       in   1  commanded right-lower gate (RDDIN), synchronous
//  cmd_lu       in   1  commanded left-upper gate (LUDIN), synchronous
//  cmd_ld       in   1  commanded left-lower gate (LDDIN), synchronous
//  fb_gate      in   4  driver gate-state feedback {LD,LU,RD,RU}, 1=on, asynchronous
//  drv_flt_n    in   2  driver desat fault {left,right}, active low, asynchronous
//  fault_clr    in   1  single-cycle clear request
//  err_unit     out  1  latched unit fault, 1=outputs must be off
//  fault_code   out  4  first fault captured since last release (0=none)
//  busy_rec     out  1  1 while in RECOVER state
// BEHAVIOUR
//  Reset: err_unit=0, fault_code=0, busy_rec=0, state=RUN, all counters and sync FFs 0.
//  fb_gate, drv_flt_n pass 2-FF synchronizers (drv_flt_n sync FFs reset to 1); cmd_* used direct.
//  Sources (evaluated every cycle on synchronized values):
//   ST_R: cmd_ru&cmd_rd; ST_L: cmd_lu&cmd_ld -> detected same cycle, no filter.
//   DS_x: per-leg counter +1 while flt_n low, cleared when high, saturates at DESAT_FILT;
//         source active when count==DESAT_FILT.
//   MM_x: per-channel counter +1 while fb!=cmd, cleared when equal, saturates at
//         FB_TIMEOUT; source active when count==FB_TIMEOUT. Counters run in all states.
//  Codes: 1 ST_R, 2 ST_L, 3 DS_R, 4 DS_L, 5 MM_RU, 6 MM_RD, 7 MM_LU, 8 MM_LD.
//   Simultaneous sources: lowest code wins.
//  FSM (registered outputs, 1-cycle latency from source active to err_unit=1):
//   RUN:     any source -> TRIP; err_unit<=1, fault_code<=winning code.
//   TRIP:    err_unit=1, fault_code held. fault_clr=1 and no source active and all cmd_*=0
//            -> RECOVER, recovery counter <=0. fault_clr under any other condition ignored.
//   RECOVER: err_unit=1, busy_rec=1; counter +1 per cycle. Any source -> TRIP,
//            fault_code<=new winning code. Counter reaching RECOVER_CYC-1 with no source
//            -> RUN; err_unit<=0, fault_code<=0, busy_rec<=0.
//  fault_code in TRIP is never overwritten by later faults (first-fault capture).
//  fault_clr in RUN or RECOVER: no effect.
//  rst_n low at any time: immediate return to reset values incl. mid-RECOVER.
//  Counter arithmetic unsigned CNT_W bits, saturating; never wraps.
// TESTING
//  cmd_ru=cmd_rd=1 one cycle in RUN -> next cycle err_unit=1, fault_code=1.
//  cmd_lu=1, fb_gate[2] held 0 -> err_unit=0 through 81 cycles after sync, then err=1, code=7.
//  fb lags cmd by 60 cycles on every edge -> err_unit stays 0 for 10k cycles.
//  drv_flt_n[0] low 7 cycles then high -> no trip; low 8+ cycles -> code=3.
//  TRIP, fault_clr with cmd_ld=1 -> stays TRIP; cmds 0, fault_clr -> busy_rec=1,
//   release after 400 cycles (err_unit=0, code=0); desat during RECOVER -> TRIP, code=3/4.
//  ST_R and DS_L same cycle -> code=1; rst_n pulse mid-RECOVER -> all outputs 0.

Source files
------------

// File: rtl/igbt_fb_monitor_if.sv
// Gate-command / driver-feedback bundle between the PWM stage, the IGBT driver and the monitor.
interface igbt_fb_monitor_if;
   logic       cmd_ru;
   logic       cmd_rd;
   logic       cmd_lu;
   logic       cmd_ld;
   logic [3:0] fb_gate;
   logic [1:0] drv_flt_n;
   logic       fault_clr;
   logic       err_unit;
   logic [3:0] fault_code;
   logic       busy_rec;

   modport master (
      output cmd_ru, cmd_rd, cmd_lu, cmd_ld, fb_gate, drv_flt_n, fault_clr,
      input  err_unit, fault_code, busy_rec
   );

   modport slave (
      input  cmd_ru, cmd_rd, cmd_lu, cmd_ld, fb_gate, drv_flt_n, fault_clr,
      output err_unit, fault_code, busy_rec
   );
endinterface

// File: rtl/igbt_fb_monitor.sv
// H-bridge gate-drive return-path monitor: shoot-through, feedback-timeout and desat
// detection with first-fault capture and a timed recovery before releasing err_unit.
module igbt_fb_monitor #(
   parameter int unsigned FB_TIMEOUT  = 80,
   parameter int unsigned DESAT_FILT  = 8,
   parameter int unsigned RECOVER_CYC = 400,
   parameter int unsigned CNT_W       = 9
) (
   input logic               clk,
   input logic               rst_n,
   igbt_fb_monitor_if.slave  bus
);

   localparam int unsigned NCH    = 4;
   localparam int unsigned NLEG   = 2;
   localparam int unsigned NSRC   = 8;
   localparam int unsigned CODE_W = 4;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_TRIP    = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   logic [NCH-1:0]             fb_s1, fb_s2;
   logic [NLEG-1:0]            flt_s1, flt_s2;
   logic [NCH-1:0]             cmd_c;
   logic [NCH-1:0][CNT_W-1:0]  mm_cnt;
   logic [NLEG-1:0][CNT_W-1:0] ds_cnt;
   logic [NSRC-1:0]            src_c;
   logic [CODE_W-1:0]          win_code_c;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  rec_cnt, rec_cnt_nxt;
   logic [CODE_W-1:0] fault_code_q, code_nxt;
   logic              err_q, busy_q;

   // Channel order {LD,LU,RD,RU} matches fb_gate
   assign cmd_c = {bus.cmd_ld, bus.cmd_lu, bus.cmd_rd, bus.cmd_ru};

   // Two-stage synchronizers; fault lines idle high so they reset to 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_s1  <= '0;
         fb_s2  <= '0;
         flt_s1 <= '1;
         flt_s2 <= '1;
      end else begin
         fb_s1  <= bus.fb_gate;
         fb_s2  <= fb_s1;
         flt_s1 <= bus.drv_flt_n;
         flt_s2 <= flt_s1;
      end
   end

   // Saturating mismatch and desat filters, running in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm_cnt <= '0;
         ds_cnt <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (fb_s2[i] != cmd_c[i]) begin
               if (mm_cnt[i] != CNT_W'(FB_TIMEOUT)) mm_cnt[i] <= mm_cnt[i] + CNT_W'(1);
            end else begin
               mm_cnt[i] <= '0;
            end
         end
         for (int j = 0; j < NLEG; j++) begin
            if (!flt_s2[j]) begin
               if (ds_cnt[j] != CNT_W'(DESAT_FILT)) ds_cnt[j] <= ds_cnt[j] + CNT_W'(1);
            end else begin
               ds_cnt[j] <= '0;
            end
         end
      end
   end

   // Source bit k corresponds to fault code k+1
   always_comb begin
      src_c    = '0;
      src_c[0] = bus.cmd_ru & bus.cmd_rd;
      src_c[1] = bus.cmd_lu & bus.cmd_ld;
      src_c[2] = (ds_cnt[0] == CNT_W'(DESAT_FILT));
      src_c[3] = (ds_cnt[1] == CNT_W'(DESAT_FILT));
      for (int i = 0; i < NCH; i++) begin
         src_c[4+i] = (mm_cnt[i] == CNT_W'(FB_TIMEOUT));
      end
   end

   // Lowest code wins: scan from the top so the lowest active index is written last
   always_comb begin
      win_code_c = '0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         if (src_c[k]) win_code_c = CODE_W'(k + 1);
      end
   end

   always_comb begin
      state_nxt   = state;
      code_nxt    = fault_code_q;
      rec_cnt_nxt = rec_cnt;
      unique case (state)
         ST_RUN: begin
            if (|src_c) begin
               state_nxt = ST_TRIP;
               code_nxt  = win_code_c;
            end
         end
         ST_TRIP: begin
            if (bus.fault_clr && !(|src_c) && !(|cmd_c)) begin
               state_nxt   = ST_RECOVER;
               rec_cnt_nxt = '0;
            end
         end
         ST_RECOVER: begin
            if (|src_c) begin
               state_nxt = ST_TRIP;
               code_nxt  = win_code_c;
            end else if (rec_cnt == CNT_W'(RECOVER_CYC - 1)) begin
               state_nxt   = ST_RUN;
               code_nxt    = '0;
               rec_cnt_nxt = '0;
            end else begin
               rec_cnt_nxt = rec_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_RUN;
            code_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         rec_cnt      <= '0;
         fault_code_q <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         rec_cnt      <= rec_cnt_nxt;
         fault_code_q <= code_nxt;
         err_q        <= (state_nxt != ST_RUN);
         busy_q       <= (state_nxt == ST_RECOVER);
      end
   end

   assign bus.err_unit   = err_q;
   assign bus.fault_code = fault_code_q;
   assign bus.busy_rec   = busy_q;

endmodule

// File: tb/tb_igbt_fb_monitor.sv
// Bench for igbt_fb_monitor: directed scenarios plus randomized traffic, checked every
// cycle against a run-length based behavioural model.
module tb_igbt_fb_monitor;

   localparam int FB_TIMEOUT  = 80;
   localparam int DESAT_FILT  = 8;
   localparam int RECOVER_CYC = 400;
   localparam int FB_LAG      = 60;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   igbt_fb_monitor_if bus ();

   igbt_fb_monitor #(
      .FB_TIMEOUT  (FB_TIMEOUT),
      .DESAT_FILT  (DESAT_FILT),
      .RECOVER_CYC (RECOVER_CYC),
      .CNT_W       (9)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: inputs seen two edges late, filters as run lengths, mode 0=run 1=trip 2=recover
   int         run_mm [4];
   int         run_ds [2];
   logic [3:0] fb_h0, fb_h1;
   logic [1:0] flt_h0, flt_h1;
   int         m_mode;
   int         m_rec;
   logic [3:0] m_code;
   logic [3:0] m_cmd;
   logic [3:0] m_fb_seen;
   logic [1:0] m_flt_seen;
   logic [8:1] m_act;
   int         m_win;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) run_mm[i] = 0;
         for (int j = 0; j < 2; j++) run_ds[j] = 0;
         fb_h0  = '0;
         fb_h1  = '0;
         flt_h0 = '1;
         flt_h1 = '1;
         m_mode = 0;
         m_rec  = 0;
         m_code = '0;
      end else begin
         m_cmd    = {bus.cmd_ld, bus.cmd_lu, bus.cmd_rd, bus.cmd_ru};
         m_act    = '0;
         m_act[1] = m_cmd[0] && m_cmd[1];
         m_act[2] = m_cmd[2] && m_cmd[3];
         m_act[3] = run_ds[0] >= DESAT_FILT;
         m_act[4] = run_ds[1] >= DESAT_FILT;
         for (int i = 0; i < 4; i++) m_act[5+i] = run_mm[i] >= FB_TIMEOUT;
         m_win = 0;
         for (int c = 1; c <= 8; c++) if (m_act[c] && m_win == 0) m_win = c;
         case (m_mode)
            0: if (m_win != 0) begin m_mode = 1; m_code = 4'(m_win); end
            1: if (bus.fault_clr && m_win == 0 && m_cmd == 4'd0) begin m_mode = 2; m_rec = 0; end
            default: begin
               if (m_win != 0) begin
                  m_mode = 1;
                  m_code = 4'(m_win);
               end else begin
                  m_rec++;
                  if (m_rec == RECOVER_CYC) begin m_mode = 0; m_code = '0; end
               end
            end
         endcase
         m_fb_seen  = fb_h1;
         fb_h1      = fb_h0;
         fb_h0      = bus.fb_gate;
         m_flt_seen = flt_h1;
         flt_h1     = flt_h0;
         flt_h0     = bus.drv_flt_n;
         for (int i = 0; i < 4; i++) run_mm[i] = (m_fb_seen[i] != m_cmd[i]) ? run_mm[i] + 1 : 0;
         for (int j = 0; j < 2; j++) run_ds[j] = (!m_flt_seen[j]) ? run_ds[j] + 1 : 0;
      end
   end

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle: compare against the model after the edge, then return at the negedge
   task automatic step();
      @(posedge clk);
      #1;
      cmp("err_unit", int'(bus.err_unit), (m_mode != 0) ? 1 : 0);
      cmp("fault_code", int'(bus.fault_code), int'(m_code));
      cmp("busy_rec", int'(bus.busy_rec), (m_mode == 2) ? 1 : 0);
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] c, input logic [3:0] fb, input logic [1:0] flt, input logic clr);
      bus.cmd_ru    = c[0];
      bus.cmd_rd    = c[1];
      bus.cmd_lu    = c[2];
      bus.cmd_ld    = c[3];
      bus.fb_gate   = fb;
      bus.drv_flt_n = flt;
      bus.fault_clr = clr;
   endtask

   task automatic do_reset();
      drive(4'd0, 4'd0, 2'b11, 1'b0);
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic lit(input string nm, input int e_err, input int e_code, input int e_busy);
      cmp({nm, "_err"}, int'(bus.err_unit), e_err);
      cmp({nm, "_code"}, int'(bus.fault_code), e_code);
      cmp({nm, "_busy"}, int'(bus.busy_rec), e_busy);
   endtask

   task automatic clear_pulse();
      bus.fault_clr = 1'b1;
      step();
      bus.fault_clr = 1'b0;
   endtask

   logic [3:0] lag_q [$];
   logic [3:0] c_v, fb_v;
   logic [1:0] flt_v;
   int         burst [2];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      drive(4'd0, 4'd0, 2'b11, 1'b0);
      @(negedge clk);
      do_reset();
      lit("reset", 0, 0, 0);

      // Shoot-through on the right leg trips next cycle
      drive(4'b0011, 4'd0, 2'b11, 1'b0);
      step();
      lit("st_r", 1, 1, 0);
      do_reset();

      // Left-upper commanded, feedback stuck off
      drive(4'b0100, 4'd0, 2'b11, 1'b0);
      repeat (FB_TIMEOUT) step();
      lit("mm_lu_pre", 0, 0, 0);
      step();
      lit("mm_lu", 1, 7, 0);
      do_reset();

      // Feedback lagging 60 cycles never trips
      lag_q = {};
      for (int i = 0; i < FB_LAG; i++) lag_q.push_back(4'd0);
      c_v = 4'd0;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(149) == 0) c_v[0] = ~c_v[0];
         if ($urandom_range(149) == 0) c_v[2] = ~c_v[2];
         fb_v = lag_q.pop_front();
         lag_q.push_back(c_v);
         drive(c_v, fb_v, 2'b11, 1'b0);
         step();
      end
      lit("lag60", 0, 0, 0);
      do_reset();

      // Desat right: 7 cycles filtered, then a real fault
      drive(4'd0, 4'd0, 2'b10, 1'b0);
      repeat (7) step();
      bus.drv_flt_n = 2'b11;
      repeat (12) step();
      lit("ds_short", 0, 0, 0);
      bus.drv_flt_n = 2'b10;
      repeat (12) step();
      lit("ds_r", 1, 3, 0);

      // Clear refused while a gate is commanded, accepted once all off
      bus.drv_flt_n = 2'b11;
      repeat (5) step();
      bus.cmd_ld = 1'b1;
      clear_pulse();
      lit("clr_cmd_on", 1, 3, 0);
      bus.cmd_ld = 1'b0;
      repeat (3) step();
      clear_pulse();
      lit("rec_enter", 1, 3, 1);
      repeat (RECOVER_CYC - 1) step();
      lit("rec_last", 1, 3, 1);
      step();
      lit("rec_done", 0, 0, 0);

      // Desat left during recovery re-trips with the new code
      drive(4'b1100, 4'd0, 2'b11, 1'b0);
      step();
      lit("st_l", 1, 2, 0);
      bus.cmd_lu = 1'b0;
      bus.cmd_ld = 1'b0;
      repeat (3) step();
      clear_pulse();
      repeat (50) step();
      lit("rec_mid", 1, 2, 1);
      bus.drv_flt_n = 2'b01;
      repeat (12) step();
      lit("ds_l_rec", 1, 4, 0);
      do_reset();

      // ST_R coincides with DS_L becoming active
      bus.drv_flt_n = 2'b01;
      repeat (10) step();
      bus.cmd_ru = 1'b1;
      bus.cmd_rd = 1'b1;
      step();
      lit("st_vs_ds", 1, 1, 0);
      do_reset();

      // Async reset mid-recovery
      drive(4'b0011, 4'd0, 2'b11, 1'b0);
      step();
      bus.cmd_ru = 1'b0;
      bus.cmd_rd = 1'b0;
      repeat (3) step();
      clear_pulse();
      repeat (100) step();
      lit("rst_pre", 1, 1, 1);
      rst_n = 1'b0;
      #1;
      lit("rst_async", 0, 0, 0);
      step();
      rst_n = 1'b1;
      step();
      lit("rst_after", 0, 0, 0);

      // Randomized traffic with quiet windows so recoveries can complete
      c_v   = 4'd0;
      fb_v  = 4'd0;
      flt_v = 2'b11;
      burst[0] = 0;
      burst[1] = 0;
      for (int n = 0; n < 20000; n++) begin
         automatic bit quiet = (n % 2000) >= 1400;
         if (quiet) begin
            c_v = 4'd0;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if ($urandom_range(63) == 0) begin
                  if (c_v[i] || !c_v[i^1] || $urandom_range(99) == 0) c_v[i] = ~c_v[i];
               end
            end
         end
         for (int i = 0; i < 4; i++) if ($urandom_range(39) == 0) fb_v[i] = c_v[i];
         for (int j = 0; j < 2; j++) begin
            if (burst[j] > 0) begin
               burst[j]--;
               flt_v[j] = 1'b0;
            end else begin
               flt_v[j] = 1'b1;
               if (!quiet && $urandom_range(299) == 0) burst[j] = int'($urandom_range(14, 1));
            end
         end
         drive(c_v, fb_v, flt_v, ($urandom_range(29) == 0) ? 1'b1 : 1'b0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
